// File: rtl/dcache_fill_ctrl.sv
// dcache_fill_ctrl
//   Line-fill controller between the data cache and data memory. On a load
//   miss it fetches the 16-word line at the cache's line base one word at a
//   time, merges write-through stores that hit the line while the fill is in
//   flight, then presents the whole line with a one-cycle RME strobe.
//
// Ports
//   CLK, RSTn            clock (posedge) and asynchronous active-low reset
//   Req, CacheRA         load miss and its 64-byte line base address
//   WE, WA, WD           write-through store snoop
//   MemRE, MemA          memory word read request and address
//   MemRD, MemValid      memory read data and its valid qualifier
//   RMD0..RMD15, RME     registered line buffer and one-cycle cache load strobe
//   Stall                pipeline hold, combinational
//   Err                  sticky fetch-timeout flag
module dcache_fill_ctrl #(
    parameter int LINE_WORDS = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req,
    input  logic [31:0] CacheRA,
    input  logic        WE,
    input  logic [31:0] WA,
    input  logic [31:0] WD,
    output logic        MemRE,
    output logic [31:0] MemA,
    input  logic [31:0] MemRD,
    input  logic        MemValid,
    output logic [31:0] RMD0,
    output logic [31:0] RMD1,
    output logic [31:0] RMD2,
    output logic [31:0] RMD3,
    output logic [31:0] RMD4,
    output logic [31:0] RMD5,
    output logic [31:0] RMD6,
    output logic [31:0] RMD7,
    output logic [31:0] RMD8,
    output logic [31:0] RMD9,
    output logic [31:0] RMD10,
    output logic [31:0] RMD11,
    output logic [31:0] RMD12,
    output logic [31:0] RMD13,
    output logic [31:0] RMD14,
    output logic [31:0] RMD15,
    output logic        RME,
    output logic        Stall,
    output logic        Err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam int                 WCNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]  WAIT_LIMIT = WCNT_W'(TIMEOUT - 1);
    localparam logic [3:0]         LAST_IDX   = 4'(LINE_WORDS - 1);

    logic [1:0]            state;
    logic [31:0]           line_base;
    logic [3:0]            idx;
    logic [LINE_WORDS-1:0] snoop_mask;
    logic [WCNT_W-1:0]     wait_cnt;
    logic                  err_q;
    logic [31:0]           line_buf [LINE_WORDS];

    logic       snoop_hit;
    logic [3:0] snoop_idx;
    logic       mem_take;

    // Byte-offset bits of both addresses carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{CacheRA[5:0], WA[1:0]};

    // Stores are only merged while a fill owns the buffer.
    assign snoop_hit = WE && (state != S_IDLE) && (WA[31:6] == line_base[31:6]);
    assign snoop_idx = WA[5:2];
    assign mem_take  = (state == S_FETCH) && MemValid;

    // Control: FSM, word index, snoop mask, wait counter, sticky error
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            line_base  <= '0;
            idx        <= '0;
            snoop_mask <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        line_base  <= {CacheRA[31:6], 6'd0};
                        idx        <= '0;
                        snoop_mask <= '0;
                        wait_cnt   <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (MemValid) begin
                        wait_cnt <= '0;
                        // idx stops at the last word; LOAD follows instead of a wrap.
                        if (idx == LAST_IDX) begin
                            state <= S_LOAD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // This wait cycle is the TIMEOUT-th: abandon the fill.
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_LOAD:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (snoop_hit) begin
                snoop_mask[snoop_idx] <= 1'b1;
            end
        end
    end

    // Line buffer: memory data unless a store already claimed the word;
    // a same-cycle store to the word being returned is written last and wins.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            if (mem_take && !snoop_mask[idx]) begin
                line_buf[idx] <= MemRD;
            end
            if (snoop_hit) begin
                line_buf[snoop_idx] <= WD;
            end
        end
    end

    assign MemRE = (state == S_FETCH);
    assign MemA  = MemRE ? (line_base + {26'd0, idx, 2'b00}) : 32'd0;
    assign RME   = (state == S_LOAD);
    assign Stall = (state != S_IDLE) || Req;
    assign Err   = err_q;

    assign RMD0  = line_buf[0];
    assign RMD1  = line_buf[1];
    assign RMD2  = line_buf[2];
    assign RMD3  = line_buf[3];
    assign RMD4  = line_buf[4];
    assign RMD5  = line_buf[5];
    assign RMD6  = line_buf[6];
    assign RMD7  = line_buf[7];
    assign RMD8  = line_buf[8];
    assign RMD9  = line_buf[9];
    assign RMD10 = line_buf[10];
    assign RMD11 = line_buf[11];
    assign RMD12 = line_buf[12];
    assign RMD13 = line_buf[13];
    assign RMD14 = line_buf[14];
    assign RMD15 = line_buf[15];

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
module tb_dcache_fill_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        Req;
    logic [31:0] CacheRA;
    logic        WE;
    logic [31:0] WA;
    logic [31:0] WD;
    logic        MemRE;
    logic [31:0] MemA;
    logic [31:0] MemRD;
    logic        MemValid;
    logic [31:0] RMD0, RMD1, RMD2, RMD3, RMD4, RMD5, RMD6, RMD7;
    logic [31:0] RMD8, RMD9, RMD10, RMD11, RMD12, RMD13, RMD14, RMD15;
    logic        RME;
    logic        Stall;
    logic        Err;

    logic [31:0] rmd [16];
    assign rmd[0]  = RMD0;   assign rmd[1]  = RMD1;   assign rmd[2]  = RMD2;   assign rmd[3]  = RMD3;
    assign rmd[4]  = RMD4;   assign rmd[5]  = RMD5;   assign rmd[6]  = RMD6;   assign rmd[7]  = RMD7;
    assign rmd[8]  = RMD8;   assign rmd[9]  = RMD9;   assign rmd[10] = RMD10;  assign rmd[11] = RMD11;
    assign rmd[12] = RMD12;  assign rmd[13] = RMD13;  assign rmd[14] = RMD14;  assign rmd[15] = RMD15;

    always #5 CLK = ~CLK;

    dcache_fill_ctrl #(.LINE_WORDS(16), .TIMEOUT(255)) dut (
        .CLK(CLK), .RSTn(RSTn), .Req(Req), .CacheRA(CacheRA),
        .WE(WE), .WA(WA), .WD(WD),
        .MemRE(MemRE), .MemA(MemA), .MemRD(MemRD), .MemValid(MemValid),
        .RMD0(RMD0), .RMD1(RMD1), .RMD2(RMD2), .RMD3(RMD3),
        .RMD4(RMD4), .RMD5(RMD5), .RMD6(RMD6), .RMD7(RMD7),
        .RMD8(RMD8), .RMD9(RMD9), .RMD10(RMD10), .RMD11(RMD11),
        .RMD12(RMD12), .RMD13(RMD13), .RMD14(RMD14), .RMD15(RMD15),
        .RME(RME), .Stall(Stall), .Err(Err)
    );

    typedef struct {
        logic [31:0] base;       // line base for Req
        int          lat;        // wait cycles before each MemValid
        logic [31:0] tag;        // memory returns tag + word index
        int          swc;        // cycle of a single store (-1: none)
        logic [31:0] swa;
        logic [31:0] swd;
        int          exp_rme;    // required RME cycle (Req at cycle 0)
        int          chk_idx;    // one hand-computed word to verify
        logic [31:0] chk_val;
        int          abort_cyc;  // cycle to pull RSTn low (0: none)
    } vec_t;

    vec_t vecs [5];

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard: addresses expected on MemA, and the expected line contents.
    logic [31:0] addr_q [$];
    logic [31:0] exp_line [16];
    bit          exp_mask [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic run_fill(input vec_t v);
        int          fidx;
        int          wcnt;
        int          rme_cyc;
        logic [31:0] a;
        logic [31:0] any_rmd;
        addr_q.delete();
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back(v.base + 32'(4 * i));
            exp_mask[i] = 1'b0;
        end
        fidx = 0; wcnt = 0; rme_cyc = -1;
        Req = 1'b1; CacheRA = v.base; WE = 1'b0; MemValid = 1'b0;
        #1;
        check("stall_cycle0", {31'd0, Stall}, 32'd1);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge CLK); #1;
            if (cyc == v.abort_cyc) begin
                RSTn = 1'b0;
                #1;
                check("rst_memre", {31'd0, MemRE}, 32'd0);
                check("rst_mema", MemA, 32'd0);
                check("rst_rme", {31'd0, RME}, 32'd0);
                check("rst_err", {31'd0, Err}, 32'd0);
                check("rst_stall_eq_req", {31'd0, Stall}, 32'd1);
                any_rmd = '0;
                for (int i = 0; i < 16; i++) any_rmd |= rmd[i];
                check("rst_rmd_clear", any_rmd, 32'd0);
                addr_q.delete();
                return;
            end
            if (rme_cyc >= 0) begin
                check("rme_single", {31'd0, RME}, 32'd0);
                check("stall_after", {31'd0, Stall}, 32'd0);
                check("memre_after", {31'd0, MemRE}, 32'd0);
                check("rmd_hold", rmd[v.chk_idx], v.chk_val);
                return;
            end
            // Memory responder: answers after v.lat wait cycles.
            if (MemRE && wcnt == v.lat) begin
                MemValid = 1'b1;
                MemRD    = v.tag + 32'(fidx);
                if (addr_q.size() == 0) begin
                    check("extra_fetch", MemA, 32'hFFFF_FFFF);
                end else begin
                    a = addr_q.pop_front();
                    check("mem_addr", MemA, a);
                end
                if (fidx < 16) begin
                    if (!exp_mask[fidx]) exp_line[fidx] = MemRD;
                    fidx++;
                end
                wcnt = 0;
            end else begin
                MemValid = 1'b0;
                if (MemRE) wcnt++;
            end
            if (cyc == v.swc) begin
                WE = 1'b1; WA = v.swa; WD = v.swd;
                if (v.swa[31:6] == v.base[31:6]) begin
                    exp_line[v.swa[5:2]] = v.swd;
                    exp_mask[v.swa[5:2]] = 1'b1;
                end
            end else begin
                WE = 1'b0;
            end
            if (RME) begin
                rme_cyc = cyc;
                check("rme_cycle", 32'(cyc), 32'(v.exp_rme));
                check("words_fetched", 32'(fidx), 32'd16);
                for (int i = 0; i < 16; i++) check($sformatf("rmd%0d", i), rmd[i], exp_line[i]);
                check("rmd_known", rmd[v.chk_idx], v.chk_val);
                Req = 1'b0;
            end
            #1;
            check("stall_in_fill", {31'd0, Stall}, 32'd1);
        end
        check("fill_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int          errc;
        bit          rme_seen;
        logic [31:0] any_rmd;

        vecs[0] = '{base: 32'h100, lat: 0, tag: 32'hA000, swc: 1, swa: 32'h108, swd: 32'hDEAD,
                    exp_rme: 17, chk_idx: 2, chk_val: 32'hDEAD, abort_cyc: 0};
        vecs[1] = '{base: 32'h100, lat: 3, tag: 32'hB000, swc: -1, swa: 32'h0, swd: 32'h0,
                    exp_rme: 65, chk_idx: 7, chk_val: 32'hB007, abort_cyc: 0};
        vecs[2] = '{base: 32'h140, lat: 0, tag: 32'hC000, swc: 5, swa: 32'h150, swd: 32'hBEEF,
                    exp_rme: 17, chk_idx: 4, chk_val: 32'hBEEF, abort_cyc: 0};
        vecs[3] = '{base: 32'h100, lat: 0, tag: 32'hD000, swc: 3, swa: 32'h200, swd: 32'h5555,
                    exp_rme: 17, chk_idx: 0, chk_val: 32'hD000, abort_cyc: 0};
        vecs[4] = '{base: 32'hFFFF_FFC0, lat: 1, tag: 32'hE000, swc: -1, swa: 32'h0, swd: 32'h0,
                    exp_rme: 33, chk_idx: 15, chk_val: 32'hE00F, abort_cyc: 0};

        RSTn = 1'b0; Req = 1'b0; CacheRA = '0; WE = 1'b0; WA = '0; WD = '0;
        MemRD = '0; MemValid = 1'b0;
        #1;
        check("reset_memre", {31'd0, MemRE}, 32'd0);
        check("reset_mema", MemA, 32'd0);
        check("reset_rme", {31'd0, RME}, 32'd0);
        check("reset_err", {31'd0, Err}, 32'd0);
        check("reset_stall_lo", {31'd0, Stall}, 32'd0);
        any_rmd = '0;
        for (int i = 0; i < 16; i++) any_rmd |= rmd[i];
        check("reset_rmd", any_rmd, 32'd0);
        Req = 1'b1; #1;
        check("reset_stall_req", {31'd0, Stall}, 32'd1);
        Req = 1'b0;
        #20;
        @(negedge CLK) RSTn = 1'b1;

        for (int k = 0; k < 5; k++) run_fill(vecs[k]);
        check("rmd5_after_plain", RMD5, 32'hE005);

        // Timeout: memory never answers.
        Req = 1'b1; CacheRA = 32'h300; MemValid = 1'b0; WE = 1'b0;
        errc = -1; rme_seen = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge CLK); #1;
            if (cyc == 1) Req = 1'b0;
            if (RME) rme_seen = 1'b1;
            if (Err) begin errc = cyc; break; end
        end
        check("timeout_err_cycle", 32'(errc), 32'd256);
        check("timeout_no_rme", {31'd0, rme_seen}, 32'd0);
        check("timeout_idle", {31'd0, MemRE}, 32'd0);

        run_fill(vecs[0]);
        check("err_sticky", {31'd0, Err}, 32'd1);

        // Reset while word 7 is outstanding, then Req held across release.
        begin
            vec_t va;
            va = vecs[3];
            va.abort_cyc = 8;
            run_fill(va);
        end
        @(negedge CLK) RSTn = 1'b1;
        run_fill(vecs[0]);
        check("err_after_reset", {31'd0, Err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
